// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: R-type func codes used by the ALU, decoder and mul/div unit,
// plus the mul/div sequencer state encoding.
package mips_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  function automatic logic fn_is_signed(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_DIV);
  endfunction

  function automatic logic fn_is_div(input logic [5:0] fn);
    return (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

  function automatic logic fn_is_muldiv(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned iterative datapath: one shift-add multiply step or one restoring divide step per cycle,
// with the iteration counter. Operands are magnitudes; sign handling lives in the caller.
module muldiv_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 div_mode,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 last_c
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               mode_q, mode_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]     sum_c;
  logic [WIDTH:0]     shl_c;
  logic [WIDTH-1:0]   diff_c;
  logic               ge_c;

  // acc holds {upper, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    sum_c  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    shl_c  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge_c   = shl_c >= {1'b0, opnd_q};
    diff_c = shl_c[WIDTH-1:0] - opnd_q;

    acc_d  = acc_q;
    opnd_d = opnd_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;

    if (load) begin
      acc_d  = {{WIDTH{1'b0}}, x};
      opnd_d = y;
      mode_d = div_mode;
      cnt_d  = CW'(WIDTH);
    end else if (step) begin
      cnt_d = cnt_q - CW'(1);
      if (mode_q) begin
        acc_d = {(ge_c ? diff_c : shl_c[WIDTH-1:0]), acc_q[WIDTH-2:0], ge_c};
      end else begin
        acc_d = {sum_c, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

  assign acc    = acc_q;
  assign last_c = (cnt_q == CW'(1));

endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO owner for the MIPS datapath: MTHI/MTLO writes plus iterative MULT/MULTU/DIV/DIVU
// sequencing with sign correction; busy stalls the pipeline while an operation runs.
module muldiv_hilo
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e state_q, state_d;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic             isdiv_q, isdiv_d;

  logic             sgn_c, a_neg_c, b_neg_c, div_mode_c;
  logic             load_c, step_c, last_c;
  logic [WIDTH-1:0] a_abs_c, b_abs_c, quo_c, rem_c;
  logic [2*WIDTH-1:0] acc, prod_c;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .step     (step_c),
    .div_mode (div_mode_c),
    .x        (a_abs_c),
    .y        (b_abs_c),
    .acc      (acc),
    .last_c   (last_c)
  );

  // operand magnitudes and sign-corrected results
  always_comb begin
    sgn_c      = fn_is_signed(func);
    div_mode_c = fn_is_div(func);
    a_neg_c    = sgn_c & a[WIDTH-1];
    b_neg_c    = sgn_c & b[WIDTH-1];
    a_abs_c    = a_neg_c ? ('0 - a) : a;
    b_abs_c    = b_neg_c ? ('0 - b) : b;
    prod_c     = qneg_q ? ('0 - acc) : acc;
    quo_c      = acc[WIDTH-1:0];
    rem_c      = acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    araw_d  = araw_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    isdiv_d = isdiv_q;
    done_d  = 1'b0;
    load_c  = 1'b0;
    step_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (func == FN_MTHI) begin
            hi_d = a;
          end else if (func == FN_MTLO) begin
            lo_d = a;
          end else if (fn_is_muldiv(func)) begin
            load_c  = 1'b1;
            isdiv_d = div_mode_c;
            qneg_d  = a_neg_c ^ b_neg_c;
            rneg_d  = a_neg_c;
            div0_d  = (b == '0);
            araw_d  = a;
            state_d = div_mode_c ? ST_DIV : ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        step_c = 1'b1;
        if (last_c) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (!isdiv_q) begin
          {hi_d, lo_d} = prod_c;
        end else if (div0_q) begin
          lo_d = '1;
          hi_d = araw_q;
        end else begin
          lo_d = qneg_q ? ('0 - quo_c) : quo_c;
          hi_d = rneg_q ? ('0 - rem_c) : rem_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      araw_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      isdiv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      araw_q  <= araw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      isdiv_q <= isdiv_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: directed corner cases plus random mul/div ops against an arithmetic model.
module tb_muldiv_hilo;
  import mips_pkg::*;

  localparam int unsigned W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   func  = '0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  logic [5:0] md_fns [4] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .func  (func),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // arithmetic reference for HI/LO after a mul/div op
  task automatic model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] eh, output logic [W-1:0] el);
    longint      sp;
    logic [63:0] up;
    int          sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    eh = '0;
    el = '0;
    case (f)
      FN_MULT: begin
        sp = longint'(sx) * longint'(sy);
        {eh, el} = sp;
      end
      FN_MULTU: begin
        up = 64'(x) * 64'(y);
        {eh, el} = up;
      end
      FN_DIV: begin
        if (y == 0) begin
          el = '1; eh = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000; eh = '0;
        end else begin
          el = 32'(sx / sy); eh = 32'(sx % sy);
        end
      end
      default: begin
        if (y == 0) begin
          el = '1; eh = x;
        end else begin
          el = x / y; eh = x % y;
        end
      end
    endcase
  endtask

  // called at a negedge; returns at the negedge of the cycle following the HI/LO update
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit poke);
    logic [W-1:0] hi0, lo0, eh, el;
    int           nb;
    bit           held_ok;
    hi0 = hi;
    lo0 = lo;
    model(f, x, y, eh, el);
    start = 1'b1; func = f; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom;
    nb = 0;
    held_ok = 1'b1;
    @(negedge clk);
    while (busy && nb < 100) begin
      nb++;
      if (hi !== hi0 || lo !== lo0 || done !== 1'b0) held_ok = 1'b0;
      if (poke && nb == 5) begin
        start = 1'b1; func = FN_MTHI; a = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("busy_cycles", 64'(nb), 64'd33);
    check_eq("hold_during_busy", 64'(held_ok), 64'd1);
    check_eq("done_pulse", 64'(done), 64'd1);
    check_eq("hi", 64'(hi), 64'(eh));
    check_eq("lo", 64'(lo), 64'(el));
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2;
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("multu_max_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check_eq("multu_max_lo", 64'(lo), 64'h0000_0000_0000_0001);
    run_op(FN_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("div_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    check_eq("div_neg_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    run_op(FN_DIVU, 32'd7, 32'd2, 1'b0);
    run_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_eq("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
    run_op(FN_DIVU, 32'h1234, 32'd0, 1'b0);
    run_op(FN_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);
    check_eq("div0_signed_hi_raw", 64'(hi), 64'h0000_0000_FFFF_FF00);

    // MTHI issued in the done cycle, then MTLO back to back
    run_op(FN_MULT, 32'd123, 32'hFFFF_FF85, 1'b0);
    start = 1'b1; func = FN_MTHI; a = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("done_one_cycle", 64'(done), 64'd0);
    check_eq("mthi_hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    check_eq("mthi_busy", 64'(busy), 64'd0);
    func = FN_MTLO; a = 32'h1234_5678;
    @(negedge clk);
    check_eq("mtlo_lo", 64'(lo), 64'h0000_0000_1234_5678);
    check_eq("mtlo_hi_kept", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    check_eq("mtlo_busy", 64'(busy), 64'd0);
    check_eq("mtlo_done", 64'(done), 64'd0);
    func = FN_MFHI; a = 32'h5555_AAAA;
    @(negedge clk);
    check_eq("other_fn_busy", 64'(busy), 64'd0);
    check_eq("other_fn_hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    check_eq("other_fn_lo", 64'(lo), 64'h0000_0000_1234_5678);
    start = 1'b0;
    @(negedge clk);

    run_op(FN_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);

    // reset in the middle of an operation
    start = 1'b1; func = FN_MULT; a = 32'h0001_0001; b = 32'h0003_0003;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_hi", 64'(hi), 64'd0);
    check_eq("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(FN_MULTU, 32'd5, 32'd6, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(md_fns[$urandom_range(0, 3)], rnd_opnd(), rnd_opnd(), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
Iterative multiply/divide unit that owns the architectural HI/LO registers of the MIPS datapath. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO using the same 6-bit R-type func encoding that drives the ALU. It presents HI/LO to the ALU operand mux so that MFHI and MFLO read them as a pass-through. Its busy output stalls the pipeline while an iterative operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH; the counter width is clog2(WIDTH)+1.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled on clk when busy=0
func  in  6  MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011
a  in  WIDTH  rs operand
b  in  WIDTH  rt operand
busy  out  1  iterative operation in flight; pipeline stall
done  out  1  one-cycle pulse; HI/LO just updated by mult/div
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and all work registers cleared.
- IDLE, start=1, MTHI: hi<=a at this edge; lo unchanged; busy and done stay 0. MTLO is the same but writes lo.
- IDLE, start=1, MULT/MULTU/DIV/DIVU:
  - Latch |a| and |b| (signed ops) or a and b (unsigned ops).
  - Latch result-sign flags: product/quotient sign = a[msb]^b[msb]; remainder sign = a[msb]. Both flags are 0 for unsigned ops.
  - Go to MUL or DIV; busy=1 from the next cycle.
- IDLE, start=1, any other func: ignored, no state change.
- start while busy=1: ignored. The pipeline must hold the request until busy=0.
- MUL: WIDTH cycles of shift-add on a 2*WIDTH product register (1 bit per cycle, LSB first). Then go to FIX.
- DIV: WIDTH cycles of restoring division (1 quotient bit per cycle, MSB first) on remainder/quotient registers. Then go to FIX.
- FIX (1 cycle):
  - Apply two's-complement sign correction.
  - Write mult: {hi,lo} <= 2*WIDTH product. Write div: lo <= quotient, hi <= remainder.
  - done=1 in the following cycle; busy=0 in the following cycle; state=IDLE.
- Latency: if the request is accepted at edge E0, busy is high for the cycles after E0 through E(WIDTH+1). HI/LO update at edge E(WIDTH+1), so 33 cycles at WIDTH=32. done is high exactly one cycle after that edge.
- Divide by zero (b=0), signed or unsigned: lo<=all ones, hi<=a (the original operand, not the absolute value). The full latency still applies.
- Signed overflow -2^31 / -1: lo<=0x80000000, hi<=0. This falls out of the abs/negate path and must not trap.
- hi/lo hold their previous values throughout MUL/DIV. Intermediate results are never visible.
- Reset asserted mid-operation: abort immediately, with all outputs at reset values. A new start is accepted in the first cycle after rst_n rises.
- start coincident with the done cycle: accepted, because busy=0 in that cycle.

Decomposition:
- Shared package (mips_pkg):
  - func localparams FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO, FN_MFHI, FN_MFLO. The ALU and the decoder share these.
  - FSM state encoding: ST_IDLE, ST_MUL, ST_DIV, ST_FIX.
- Sub-module: muldiv_core, the datapath for one shift-add/restoring step plus the counter. The FSM, sign handling and the HI/LO registers stay in the top.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> at cycle 33 after accept: hi=0xFFFFFFFE, lo=0x00000001; done pulses once; busy high for exactly 33 cycles.
- MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7 b=2 -> lo=3, hi=1.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- MTHI a=0xDEADBEEF, then MTLO a=0x12345678 on the next cycle -> hi/lo updated at each edge; busy and done stay 0. A start issued during MULT busy is ignored, and the final result is unaffected.
- Start MULT, then assert rst_n=0 at cycle 10 -> busy, done, hi and lo are 0 immediately. Release reset and issue MULTU 5*6 -> lo=30, hi=0 after 33 cycles.
